// File: rtl/phys_free_list_if.sv
// Rename/retire-side signal bundle for the physical-register free list.
// The master is the rename/retire logic; the slave is the free list itself.
interface phys_free_list_if #(
  parameter int PREG_W = 6
);
  logic              alloc_req_a;
  logic              alloc_req_b;
  logic              alloc_gnt;
  logic [PREG_W-1:0] alloc_preg_a;
  logic [PREG_W-1:0] alloc_preg_b;
  logic              free_valid_a;
  logic [PREG_W-1:0] free_preg_a;
  logic              free_valid_b;
  logic [PREG_W-1:0] free_preg_b;
  logic [PREG_W-1:0] free_count;
  logic              overflow_err;

  modport master (
    output alloc_req_a, alloc_req_b, free_valid_a, free_preg_a, free_valid_b, free_preg_b,
    input  alloc_gnt, alloc_preg_a, alloc_preg_b, free_count, overflow_err
  );

  modport slave (
    input  alloc_req_a, alloc_req_b, free_valid_a, free_preg_a, free_valid_b, free_preg_b,
    output alloc_gnt, alloc_preg_a, alloc_preg_b, free_count, overflow_err
  );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical registers for a 2-wide rename stage.
// Pops up to two pregs per cycle (all-or-nothing), pushes up to two retired pregs.
module phys_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 6,
  parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic           clk,
  input  logic           reset,
  phys_free_list_if.slave bus
);

  localparam int                PTR_W   = $clog2(FL_DEPTH);
  localparam logic [PREG_W-1:0] DEPTH_C = PREG_W'(FL_DEPTH);

  logic [PREG_W-1:0] r_entry [FL_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PREG_W-1:0] r_count;
  logic              r_ovf;

  logic [1:0]        w_n_req;
  logic              w_gnt;
  logic [PTR_W-1:0]  w_head1;
  logic [PTR_W-1:0]  w_tail_b;
  logic [PREG_W-1:0] w_pop;
  logic [PREG_W-1:0] w_after_pop;
  logic [PREG_W-1:0] w_space;
  logic              w_push_a;
  logic              w_push_b;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_drop;

  // Slot A has priority for the remaining room, so B is the first push dropped.
  function automatic logic [1:0] accept_pushes(input logic [PREG_W-1:0] space,
                                               input logic pa, input logic pb);
    logic ka;
    logic kb;
    ka = pa && (space != '0);
    kb = pb && (space > (ka ? PREG_W'(1) : PREG_W'(0)));
    return {kb, ka};
  endfunction

  always_comb begin
    w_n_req     = {1'b0, bus.alloc_req_a} + {1'b0, bus.alloc_req_b};
    w_gnt       = (w_n_req != 2'd0) && (PREG_W'(w_n_req) <= r_count);
    w_head1     = r_head + PTR_W'(1);
    w_pop       = w_gnt ? PREG_W'(w_n_req) : '0;
    w_after_pop = r_count - w_pop;
    w_space     = DEPTH_C - w_after_pop;
    // p0 is the hardwired zero register and never re-enters the list.
    w_push_a    = bus.free_valid_a && (bus.free_preg_a != '0);
    w_push_b    = bus.free_valid_b && (bus.free_preg_b != '0);
    {w_acc_b, w_acc_a} = accept_pushes(w_space, w_push_a, w_push_b);
    w_drop      = (w_push_a && !w_acc_a) || (w_push_b && !w_acc_b);
    w_tail_b    = r_tail + PTR_W'(w_acc_a);
  end

  assign bus.alloc_gnt    = w_gnt;
  assign bus.alloc_preg_a = r_entry[r_head];
  assign bus.alloc_preg_b = bus.alloc_req_a ? r_entry[w_head1] : r_entry[r_head];
  assign bus.free_count   = r_count;
  assign bus.overflow_err = r_ovf;

  // Reads above use pre-edge state, so a push landing on a slot popped this cycle is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_entry[i] <= PREG_W'(ARCH_REGS + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= DEPTH_C;
      r_ovf   <= 1'b0;
    end else begin
      if (w_gnt) r_head <= r_head + PTR_W'(w_n_req);
      if (w_acc_a) r_entry[r_tail] <= bus.free_preg_a;
      if (w_acc_b) r_entry[w_tail_b] <= bus.free_preg_b;
      r_tail  <= r_tail + PTR_W'(w_acc_a) + PTR_W'(w_acc_b);
      r_count <= w_after_pop + PREG_W'(w_acc_a) + PREG_W'(w_acc_b);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus random traffic against a queue model.
module tb_phys_free_list;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   q[$];
  bit   m_ovf;

  phys_free_list_if #(.PREG_W(6)) bus ();

  phys_free_list dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_init();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    m_ovf = 1'b0;
  endfunction

  function automatic int n_req();
    return int'(bus.alloc_req_a) + int'(bus.alloc_req_b);
  endfunction

  function automatic bit exp_gnt();
    return (n_req() != 0) && (n_req() <= q.size());
  endfunction

  function automatic int exp_pa();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  function automatic int exp_pb();
    if (bus.alloc_req_a) return (q.size() > 1) ? q[1] : 0;
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  // Free list as a FIFO of preg numbers: pop front on grant, append retired pregs.
  function automatic void model_edge();
    int pushes[$];
    if (reset) begin
      model_init();
      return;
    end
    if (exp_gnt()) begin
      for (int k = 0; k < n_req(); k++) void'(q.pop_front());
    end
    if (bus.free_valid_a && bus.free_preg_a != 0) pushes.push_back(int'(bus.free_preg_a));
    if (bus.free_valid_b && bus.free_preg_b != 0) pushes.push_back(int'(bus.free_preg_b));
    foreach (pushes[k]) begin
      if (q.size() < 32) q.push_back(pushes[k]);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic drive(input bit a, input bit b, input bit va, input int pa,
                       input bit vb, input int pb);
    bus.alloc_req_a  = a;
    bus.alloc_req_b  = b;
    bus.free_valid_a = va;
    bus.free_preg_a  = 6'(pa);
    bus.free_valid_b = vb;
    bus.free_preg_b  = 6'(pb);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.free_count !== 6'd32) begin
      errors++; $display("FAIL reset_count got %0d want 32", bus.free_count);
    end
    checks++;
    if (bus.alloc_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got %b want 0", bus.alloc_gnt);
    end
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow_err);
    end
  endtask

  task automatic test_dual_then_single_b();
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_a !== 6'd32 || bus.alloc_preg_b !== 6'd33) begin
      errors++;
      $display("FAIL dual_alloc got gnt=%b a=%0d b=%0d want gnt=1 a=32 b=33",
               bus.alloc_gnt, bus.alloc_preg_a, bus.alloc_preg_b);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.free_count !== 6'd30 || bus.alloc_preg_a !== 6'd34) begin
      errors++;
      $display("FAIL dual_after got count=%0d head=%0d want 30/34", bus.free_count, bus.alloc_preg_a);
    end
    drive(0, 1, 0, 0, 0, 0);
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_b !== 6'd34) begin
      errors++;
      $display("FAIL single_b got gnt=%b b=%0d want gnt=1 b=34", bus.alloc_gnt, bus.alloc_preg_b);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.free_count !== 6'd29) begin
      errors++; $display("FAIL single_b_count got %0d want 29", bus.free_count);
    end
  endtask

  task automatic test_drain_and_no_partial();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1, 1, 0, 0, 0, 0);
      checks++;
      if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_a !== 6'(32 + 2*k) ||
          bus.alloc_preg_b !== 6'(33 + 2*k)) begin
        errors++;
        $display("FAIL drain_%0d got gnt=%b a=%0d b=%0d want 1/%0d/%0d", k, bus.alloc_gnt,
                 bus.alloc_preg_a, bus.alloc_preg_b, 32 + 2*k, 33 + 2*k);
      end
      tick();
    end
    drive(1, 0, 1, 5, 0, 0);
    checks++;
    if (bus.alloc_gnt !== 1'b0 || bus.free_count !== 6'd0) begin
      errors++;
      $display("FAIL empty_free got gnt=%b count=%0d want 0/0", bus.alloc_gnt, bus.free_count);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.free_count !== 6'd1 || bus.alloc_gnt !== 1'b1 || bus.alloc_preg_a !== 6'd5) begin
      errors++;
      $display("FAIL refill got count=%0d gnt=%b a=%0d want 1/1/5",
               bus.free_count, bus.alloc_gnt, bus.alloc_preg_a);
    end
    tick();
    drive(0, 0, 1, 5, 0, 0);
    tick();
    drive(1, 1, 1, 0, 1, 7);
    checks++;
    if (bus.alloc_gnt !== 1'b0 || bus.free_count !== 6'd1) begin
      errors++;
      $display("FAIL no_partial got gnt=%b count=%0d want 0/1", bus.alloc_gnt, bus.free_count);
    end
    tick();
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if (bus.free_count !== 6'd2 || bus.alloc_gnt !== 1'b1 ||
        bus.alloc_preg_a !== 6'd5 || bus.alloc_preg_b !== 6'd7) begin
      errors++;
      $display("FAIL p0_skip got count=%0d gnt=%b a=%0d b=%0d want 2/1/5/7",
               bus.free_count, bus.alloc_gnt, bus.alloc_preg_a, bus.alloc_preg_b);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(1, 1, 1, $urandom_range(63, 1), 1, $urandom_range(63, 1));
      checks++;
      if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_a !== 6'(exp_pa()) ||
          bus.alloc_preg_b !== 6'(exp_pb()) || bus.free_count !== 6'd32) begin
        errors++;
        $display("FAIL wrap_%0d got gnt=%b a=%0d b=%0d count=%0d want 1/%0d/%0d/32", k,
                 bus.alloc_gnt, bus.alloc_preg_a, bus.alloc_preg_b, bus.free_count,
                 exp_pa(), exp_pb());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++; $display("FAIL wrap_ovf got %b want 0", bus.overflow_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(0, 0, 1, 9, 1, 10);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.free_count !== 6'd32 || bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow got count=%0d ovf=%b want 32/1", bus.free_count, bus.overflow_err);
    end
    drive(1, 1, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd28) begin
      errors++;
      $display("FAIL ovf_sticky got ovf=%b count=%0d want 1/28", bus.overflow_err, bus.free_count);
    end
    do_reset();
    #1;
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", bus.overflow_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(79, 0) == 0);
      drive($urandom_range(9, 0) < 6, $urandom_range(9, 0) < 6,
            $urandom_range(9, 0) < 5, $urandom_range(63, 0),
            $urandom_range(9, 0) < 5, $urandom_range(63, 0));
      checks++;
      if (bus.alloc_gnt !== exp_gnt()) begin
        errors++; $display("FAIL rnd_gnt_%0d got %b want %b", k, bus.alloc_gnt, exp_gnt());
      end
      if (exp_gnt() && bus.alloc_req_a) begin
        checks++;
        if (bus.alloc_preg_a !== 6'(exp_pa())) begin
          errors++; $display("FAIL rnd_pa_%0d got %0d want %0d", k, bus.alloc_preg_a, exp_pa());
        end
      end
      if (exp_gnt() && bus.alloc_req_b) begin
        checks++;
        if (bus.alloc_preg_b !== 6'(exp_pb())) begin
          errors++; $display("FAIL rnd_pb_%0d got %0d want %0d", k, bus.alloc_preg_b, exp_pb());
        end
      end
      checks++;
      if (bus.free_count !== 6'(q.size()) || bus.overflow_err !== m_ovf) begin
        errors++;
        $display("FAIL rnd_state_%0d got count=%0d ovf=%b want %0d/%b", k,
                 bus.free_count, bus.overflow_err, q.size(), m_ovf);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    model_init();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_dual_then_single_b();
    test_drain_and_no_partial();
    test_wrap();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
